// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants and types for the 4-way round-robin arbiter in front of a Mux_4to1 resource.
package arb_pkg;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] RR_RESET_PTR = 2'd3;

    function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/resource-side signals of the arbiter; slave is the arbiter, master drives requests.
interface mux4_rr_arbiter_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req_i;
    logic             done_i;
    logic [N_REQ-1:0] grant_o;
    logic [SEL_W-1:0] select_o;
    logic             busy_o;
    logic             timeout_o;

    modport slave (
        input  req_i, done_i,
        output grant_o, select_o, busy_o, timeout_o
    );

    modport master (
        output req_i, done_i,
        input  grant_o, select_o, busy_o, timeout_o
    );
endinterface

// File: rtl/mux4_rr_arbiter_pick.sv
// Combinational round-robin pick: the requester just after ptr has highest priority, ptr itself the lowest.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] win
);
    logic [SEL_W-1:0]   w_base;
    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [SEL_W-1:0]   w_idx;

    assign w_base = ptr + 2'd1;
    assign w_dbl  = {req, req} >> w_base;
    assign w_rot  = w_dbl[N_REQ-1:0];

    always_comb begin
        w_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_idx = SEL_W'(i);
        end
    end

    assign any = |req;
    assign win = w_base + w_idx;
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1-muxed resource; grant held until done, abandon or watchdog,
// with zero-bubble handoff to the next requester.
module mux4_rr_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mux4_rr_arbiter_if.slave   bus
);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    state_t           r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_sel;
    logic [N_REQ-1:0] r_grant;
    logic [HW-1:0]    r_hold;
    logic             r_timeout;

    logic             w_any;
    logic [SEL_W-1:0] w_win;
    logic             w_abandon;
    logic             w_wd;
    logic             w_release;
    logic             w_wd_only;

    // Same picker serves IDLE and handoff: in GRANT r_ptr is the owner, so it ranks last.
    rr_pick4 u_pick (
        .req (bus.req_i),
        .ptr (r_ptr),
        .any (w_any),
        .win (w_win)
    );

    assign w_abandon = ~bus.req_i[r_sel];
    assign w_wd      = (MAX_HOLD != 0) && (r_hold == HOLD_LAST);
    assign w_release = bus.done_i | w_abandon | w_wd;
    assign w_wd_only = w_wd & ~bus.done_i & ~w_abandon;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= ST_IDLE;
            r_ptr     <= RR_RESET_PTR;
            r_sel     <= '0;
            r_grant   <= '0;
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_GRANT;
                        r_grant <= onehot4(w_win);
                        r_sel   <= w_win;
                        r_ptr   <= w_win;
                        r_hold  <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_timeout <= w_wd_only;
                        if (w_any) begin
                            r_grant <= onehot4(w_win);
                            r_sel   <= w_win;
                            r_ptr   <= w_win;
                            r_hold  <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_grant <= '0;
                        end
                    end else if (r_hold != '1) begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.grant_o   = r_grant;
    assign bus.select_o  = r_sel;
    assign bus.busy_o    = (r_state == ST_GRANT);
    assign bus.timeout_o = r_timeout;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scenario bench for mux4_rr_arbiter: expected {grant,select,busy,timeout} queued per driven cycle.
module tb_mux4_rr_arbiter;
    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    mux4_rr_arbiter_if bus();
    mux4_rr_arbiter #(.MAX_HOLD(8)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_v;
    logic [7:0] obs;

    function automatic logic [7:0] pk(input logic [3:0] g, input logic [1:0] s, input logic t);
        return {g, s, (g != 4'b0000), t};
    endfunction

    task automatic drive(input logic [3:0] r, input logic d, input logic [7:0] e);
        bus.req_i  = r;
        bus.done_i = d;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        bus.req_i = 4'hF;
        bus.done_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(pk(4'b0000, 2'd0, 1'b0));
            @(posedge clk_i);
            #1;
            exp_v = sb.pop_front();
            obs = {bus.grant_o, bus.select_o, bus.busy_o, bus.timeout_o};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL reset step %0d: got g/s/b/t=%b/%b/%b/%b required %b/%b/%b/%b", i,
                         obs[7:4], obs[3:2], obs[1], obs[0], exp_v[7:4], exp_v[3:2], exp_v[1], exp_v[0]);
            end
        end
        rst_i = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [3:0] rq[7];
        logic       dn[7];
        logic [3:0] eg[7];
        logic [1:0] es[7];
        rq = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0};
        dn = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000};
        es = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
        for (int i = 0; i < 7; i++) begin
            drive(rq[i], dn[i], pk(eg[i], es[i], 1'b0));
            exp_v = sb.pop_front();
            obs = {bus.grant_o, bus.select_o, bus.busy_o, bus.timeout_o};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL round_robin step %0d: got g/s/b/t=%b/%b/%b/%b required %b/%b/%b/%b", i,
                         obs[7:4], obs[3:2], obs[1], obs[0], exp_v[7:4], exp_v[3:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    task automatic test_watchdog();
        logic [3:0] r;
        logic [3:0] g;
        for (int i = 0; i < 11; i++) begin
            r = (i < 10) ? 4'b0100 : 4'b0000;
            g = (i < 10) ? 4'b0100 : 4'b0000;
            drive(r, 1'b0, pk(g, 2'd2, (i == 8)));
            exp_v = sb.pop_front();
            obs = {bus.grant_o, bus.select_o, bus.busy_o, bus.timeout_o};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL watchdog step %0d: got g/s/b/t=%b/%b/%b/%b required %b/%b/%b/%b", i,
                         obs[7:4], obs[3:2], obs[1], obs[0], exp_v[7:4], exp_v[3:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    task automatic test_abandon();
        logic [3:0] rq[4];
        logic [3:0] eg[4];
        logic [1:0] es[4];
        rq = '{4'b0010, 4'b1010, 4'b1000, 4'b0000};
        eg = '{4'b0010, 4'b0010, 4'b1000, 4'b0000};
        es = '{2'd1, 2'd1, 2'd3, 2'd3};
        for (int i = 0; i < 4; i++) begin
            drive(rq[i], 1'b0, pk(eg[i], es[i], 1'b0));
            exp_v = sb.pop_front();
            obs = {bus.grant_o, bus.select_o, bus.busy_o, bus.timeout_o};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL abandon step %0d: got g/s/b/t=%b/%b/%b/%b required %b/%b/%b/%b", i,
                         obs[7:4], obs[3:2], obs[1], obs[0], exp_v[7:4], exp_v[3:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    task automatic test_done_vs_watchdog();
        logic [3:0] r;
        logic       d;
        logic [3:0] g;
        logic [1:0] s;
        for (int i = 0; i < 10; i++) begin
            r = (i < 8) ? 4'b0001 : (i == 8) ? 4'b0011 : 4'b0000;
            d = (i == 8);
            g = (i < 8) ? 4'b0001 : (i == 8) ? 4'b0010 : 4'b0000;
            s = (i < 8) ? 2'd0 : 2'd1;
            drive(r, d, pk(g, s, 1'b0));
            exp_v = sb.pop_front();
            obs = {bus.grant_o, bus.select_o, bus.busy_o, bus.timeout_o};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL done_vs_wd step %0d: got g/s/b/t=%b/%b/%b/%b required %b/%b/%b/%b", i,
                         obs[7:4], obs[3:2], obs[1], obs[0], exp_v[7:4], exp_v[3:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(4'b0100, 1'b0, pk(4'b0100, 2'd2, 1'b0));
                1: begin
                    // asynchronous: observe before any further clock edge
                    rst_i = 1'b0;
                    sb.push_back(pk(4'b0000, 2'd0, 1'b0));
                    #1;
                end
                2: drive(4'b1010, 1'b0, pk(4'b0000, 2'd0, 1'b0));
                3: begin
                    rst_i = 1'b1;
                    drive(4'b1010, 1'b0, pk(4'b0010, 2'd1, 1'b0));
                end
                default: drive(4'b0000, 1'b1, pk(4'b0000, 2'd1, 1'b0));
            endcase
            exp_v = sb.pop_front();
            obs = {bus.grant_o, bus.select_o, bus.busy_o, bus.timeout_o};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL reset_mid step %0d: got g/s/b/t=%b/%b/%b/%b required %b/%b/%b/%b", i,
                         obs[7:4], obs[3:2], obs[1], obs[0], exp_v[7:4], exp_v[3:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_watchdog();
        test_abandon();
        test_done_vs_watchdog();
        test_reset_mid_grant();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d leftover entries required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
